// File: rtl/regfile_write_arbiter_if.sv
// Write-port sharing bundle: two writeback requesters, clear control,
// and the registered register-file write port.
// Ports: a_*/b_* valid/reg/data with ready back, clr_start/clr_busy,
//   RegWrite/WriteReg/WriteData toward the register file.
interface regfile_write_arbiter_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
);
    logic              a_valid;
    logic [ADDR_W-1:0] a_reg;
    logic [DATA_W-1:0] a_data;
    logic              a_ready;
    logic              b_valid;
    logic [ADDR_W-1:0] b_reg;
    logic [DATA_W-1:0] b_data;
    logic              b_ready;
    logic              clr_start;
    logic              clr_busy;
    logic              RegWrite;
    logic [ADDR_W-1:0] WriteReg;
    logic [DATA_W-1:0] WriteData;

    modport master (
        output a_valid, a_reg, a_data,
        input  a_ready,
        output b_valid, b_reg, b_data,
        input  b_ready,
        output clr_start,
        input  clr_busy,
        input  RegWrite, WriteReg, WriteData
    );

    modport slave (
        input  a_valid, a_reg, a_data,
        output a_ready,
        input  b_valid, b_reg, b_data,
        output b_ready,
        input  clr_start,
        output clr_busy,
        output RegWrite, WriteReg, WriteData
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing one register-file write port between ALU (A)
// and load (B) writeback, with a sweep that zeroes every register.
// Ports: clk, rst_n (async, active low), wb (slave side of the bundle).
module regfile_write_arbiter #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3,
    parameter int NREG   = 8
) (
    input logic                  clk,
    input logic                  rst_n,
    regfile_write_arbiter_if.slave wb
);
    typedef enum logic {ARB, CLEAR} state_t;

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NREG - 1);

    state_t            state;
    logic              last_b;
    logic [ADDR_W-1:0] clr_cnt;
    logic              arb_on;
    logic              a_rdy;
    logic              b_rdy;

    // On a tie the requester that did not win last time is served.
    always_comb begin
        arb_on = (state == ARB) && !wb.clr_start;
        a_rdy  = arb_on && wb.a_valid
                 && (!wb.b_valid || last_b);
        b_rdy  = arb_on && wb.b_valid
                 && (!wb.a_valid || !last_b);
    end

    assign wb.a_ready = a_rdy;
    assign wb.b_ready = b_rdy;

    // clr_cnt tracks the index currently on WriteReg during a sweep, so the
    // first zeroing write is issued on the edge that enters CLEAR.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ARB;
            last_b       <= 1'b1;
            clr_cnt      <= '0;
            wb.clr_busy  <= 1'b0;
            wb.RegWrite  <= 1'b0;
            wb.WriteReg  <= '0;
            wb.WriteData <= '0;
        end else begin
            unique case (state)
                ARB: begin
                    if (wb.clr_start) begin
                        state        <= CLEAR;
                        wb.clr_busy  <= 1'b1;
                        clr_cnt      <= '0;
                        wb.RegWrite  <= 1'b1;
                        wb.WriteReg  <= '0;
                        wb.WriteData <= '0;
                    end else if (a_rdy) begin
                        wb.RegWrite  <= 1'b1;
                        wb.WriteReg  <= wb.a_reg;
                        wb.WriteData <= wb.a_data;
                        last_b       <= 1'b0;
                    end else if (b_rdy) begin
                        wb.RegWrite  <= 1'b1;
                        wb.WriteReg  <= wb.b_reg;
                        wb.WriteData <= wb.b_data;
                        last_b       <= 1'b1;
                    end else begin
                        wb.RegWrite  <= 1'b0;
                    end
                end
                CLEAR: begin
                    if (clr_cnt == LAST) begin
                        state       <= ARB;
                        wb.clr_busy <= 1'b0;
                        clr_cnt     <= '0;
                        wb.RegWrite <= 1'b0;
                    end else begin
                        clr_cnt      <= clr_cnt + 1'b1;
                        wb.RegWrite  <= 1'b1;
                        wb.WriteReg  <= clr_cnt + 1'b1;
                        wb.WriteData <= '0;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter with a queue-based reference
// model checked every cycle plus literal expectations per scenario.
module tb_regfile_write_arbiter;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 3;
    localparam int NREG   = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    regfile_write_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    regfile_write_arbiter #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREG(NREG)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .wb    (bus.slave)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // Reference model: pending sweep writes live in a queue; arbitration
    // simply prefers whichever requester was not served last.
    int          sweep_q[$];
    bit          m_last_b;
    bit          m_rw;
    int          m_reg;
    int          m_data;

    always @(negedge clk) begin
        if (!rst_n) begin
            sweep_q.delete();
            m_last_b = 1'b1;
            m_rw = 1'b0;
            m_reg = 0;
            m_data = 0;
            chk("rst_rw", 32'(bus.RegWrite), 0);
            chk("rst_busy", 32'(bus.clr_busy), 0);
            chk("rst_reg", 32'(bus.WriteReg), 0);
            chk("rst_data", 32'(bus.WriteData), 0);
        end else begin
            bit busy, arb, ea, eb;
            busy = sweep_q.size() > 0;
            arb  = !busy && !bus.clr_start;
            ea = arb && bus.a_valid && (!bus.b_valid || m_last_b);
            eb = arb && bus.b_valid && (!bus.a_valid || !m_last_b);
            chk("m_busy", 32'(bus.clr_busy), 32'(busy));
            chk("m_rw", 32'(bus.RegWrite), 32'(m_rw));
            chk("m_reg", 32'(bus.WriteReg), 32'(m_reg));
            chk("m_data", 32'(bus.WriteData), 32'(m_data));
            chk("m_a_ready", 32'(bus.a_ready), 32'(ea));
            chk("m_b_ready", 32'(bus.b_ready), 32'(eb));
            if (busy) begin
                void'(sweep_q.pop_front());
                if (sweep_q.size() > 0) begin
                    m_rw = 1'b1;
                    m_reg = sweep_q[0];
                    m_data = 0;
                end else begin
                    m_rw = 1'b0;
                end
            end else if (bus.clr_start) begin
                for (int i = 0; i < NREG; i++) sweep_q.push_back(i);
                m_rw = 1'b1;
                m_reg = sweep_q[0];
                m_data = 0;
            end else if (ea) begin
                m_rw = 1'b1;
                m_reg = int'(bus.a_reg);
                m_data = int'(bus.a_data);
                m_last_b = 1'b0;
            end else if (eb) begin
                m_rw = 1'b1;
                m_reg = int'(bus.b_reg);
                m_data = int'(bus.b_data);
                m_last_b = 1'b1;
            end else begin
                m_rw = 1'b0;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
    endtask

    initial begin
        bus.a_valid = 0; bus.a_reg = 0; bus.a_data = 0;
        bus.b_valid = 0; bus.b_reg = 0; bus.b_data = 0;
        bus.clr_start = 0;
        cyc();
        do_reset();

        // 1: single A write, one-cycle latency
        bus.a_valid = 1; bus.a_reg = 3; bus.a_data = 16'h1234;
        #1 chk("t1_a_ready", 32'(bus.a_ready), 1);
        cyc();
        bus.a_valid = 0;
        #1;
        chk("t1_rw", 32'(bus.RegWrite), 1);
        chk("t1_reg", 32'(bus.WriteReg), 3);
        chk("t1_data", 32'(bus.WriteData), 32'h1234);
        cyc();
        #1 chk("t1_rw_off", 32'(bus.RegWrite), 0);

        // 2: both valid from reset -> A,B,A,B
        do_reset();
        bus.a_valid = 1; bus.a_reg = 1; bus.a_data = 16'hAAAA;
        bus.b_valid = 1; bus.b_reg = 2; bus.b_data = 16'hBBBB;
        #1 chk("t2_first_a", 32'(bus.a_ready), 1);
        for (int k = 1; k <= 4; k++) begin
            cyc();
            if (k == 4) begin
                bus.a_valid = 0;
                bus.b_valid = 0;
            end
            #1;
            chk("t2_rw", 32'(bus.RegWrite), 1);
            chk("t2_reg", 32'(bus.WriteReg), (k % 2) ? 1 : 2);
            chk("t2_data", 32'(bus.WriteData),
                (k % 2) ? 32'hAAAA : 32'hBBBB);
        end

        // 3: clear sweep with A waiting
        bus.a_valid = 1; bus.a_reg = 4; bus.a_data = 16'h4444;
        bus.clr_start = 1;
        #1 chk("t3_a_blocked", 32'(bus.a_ready), 0);
        for (int i = 0; i < NREG; i++) begin
            cyc();
            bus.clr_start = 0;
            #1;
            chk("t3_busy", 32'(bus.clr_busy), 1);
            chk("t3_rw", 32'(bus.RegWrite), 1);
            chk("t3_reg", 32'(bus.WriteReg), 32'(i));
            chk("t3_data", 32'(bus.WriteData), 0);
        end
        cyc();
        #1;
        chk("t3_done", 32'(bus.clr_busy), 0);
        chk("t3_a_ready", 32'(bus.a_ready), 1);
        cyc();
        bus.a_valid = 0;
        #1 chk("t3_a_write", 32'(bus.WriteData), 32'h4444);

        // 4: clr_start during sweep is ignored
        bus.clr_start = 1;
        for (int i = 0; i < NREG; i++) begin
            cyc();
            bus.clr_start = (i == 4);
            #1 chk("t4_reg", 32'(bus.WriteReg), 32'(i));
        end
        cyc();
        #1;
        chk("t4_done", 32'(bus.clr_busy), 0);
        chk("t4_rw", 32'(bus.RegWrite), 0);

        // 5: reset aborts sweep
        bus.clr_start = 1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            bus.clr_start = 0;
        end
        rst_n = 0;
        #1;
        chk("t5_rw", 32'(bus.RegWrite), 0);
        chk("t5_busy", 32'(bus.clr_busy), 0);
        cyc();
        rst_n = 1;
        bus.b_valid = 1; bus.b_reg = 5; bus.b_data = 16'h00FF;
        #1 chk("t5_b_ready", 32'(bus.b_ready), 1);
        cyc();
        bus.b_valid = 0;
        #1;
        chk("t5_reg", 32'(bus.WriteReg), 5);
        chk("t5_data", 32'(bus.WriteData), 32'h00FF);

        // 6: after B-only traffic, a tie goes to A
        bus.b_valid = 1; bus.b_reg = 6; bus.b_data = 16'h0606;
        for (int i = 0; i < 3; i++) cyc();
        bus.a_valid = 1; bus.a_reg = 7; bus.a_data = 16'h0707;
        #1;
        chk("t6_a_ready", 32'(bus.a_ready), 1);
        chk("t6_b_wait", 32'(bus.b_ready), 0);
        cyc();
        bus.a_valid = 0;
        #1;
        chk("t6_a_reg", 32'(bus.WriteReg), 7);
        chk("t6_b_ready", 32'(bus.b_ready), 1);
        cyc();
        bus.b_valid = 0;
        #1 chk("t6_b_reg", 32'(bus.WriteReg), 6);
        cyc();
        cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
